keypad_operand_entry: RTL and testbench

//  Parametrised operand-entry unit for the calculator datapath. It sits after keypad_input.
//  It collects up to DIGITS decimal key presses plus sign, backspace, clear and enter commands.
//  On enter it converts the BCD entry to binary over multiple cycles and range-checks it.
//  It then presents a WIDTH-bit two's-complement operand on a valid/ready handshake to the ALU.

---
 rtl/keypad_operand_entry.sv | 175 +++++++++++++++++
 tb/tb_keypad_operand_entry.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_operand_entry.sv
// ============================================================================
// Module   : keypad_operand_entry
// Brief    : Keypad operand entry: BCD digit buffer with sign, serial BCD->binary
//            conversion, saturating range check, valid/ready operand output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_operand_entry #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_key_valid,
    input  logic [3:0]            i_key_code,
    output logic [WIDTH-1:0]      o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_range_err,
    output logic                  o_busy,
    output logic [4*DIGITS-1:0]   o_disp_bcd,
    output logic                  o_disp_neg,
    output logic [2:0]            o_digit_count
);

    localparam int          c_AW       = 4 * DIGITS;
    localparam logic [31:0] c_MAXP     = (32'd1 << (WIDTH - 1)) - 32'd1;
    localparam logic [31:0] c_MAXN     = 32'd1 << (WIDTH - 1);
    localparam logic [2:0]  c_DIGITS   = 3'(DIGITS);
    localparam logic [2:0]  c_LAST_IDX = 3'(DIGITS - 1);

    localparam logic [3:0]  c_KEY_NEG  = 4'hA;
    localparam logic [3:0]  c_KEY_BS   = 4'hB;
    localparam logic [3:0]  c_KEY_CLR  = 4'hC;
    localparam logic [3:0]  c_KEY_ENT  = 4'hE;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_CONV  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_AW-1:0]   r_buf,   w_buf_nxt;
    logic [2:0]        r_count, w_count_nxt;
    logic              r_neg,   w_neg_nxt;
    logic [c_AW-1:0]   r_acc,   w_acc_nxt;
    logic [2:0]        r_idx,   w_idx_nxt;
    logic [WIDTH-1:0]  r_data,  w_data_nxt;
    logic              r_err,   w_err_nxt;

    logic [3:0]        w_digit;
    logic [c_AW-1:0]   w_acc_step;
    logic [31:0]       w_acc32;
    logic [WIDTH-1:0]  w_sat_data;
    logic              w_sat_err;
    logic              w_key_clr;

    // Buffer scanned most-significant position first during conversion
    assign w_digit    = r_buf[4*r_idx +: 4];
    assign w_acc_step = r_acc * c_AW'(10) + c_AW'(w_digit);
    assign w_acc32    = 32'(w_acc_step);
    assign w_key_clr  = i_key_valid && (i_key_code == c_KEY_CLR);

    always_comb begin
        w_sat_data = w_acc32[WIDTH-1:0];
        w_sat_err  = 1'b0;
        if (!r_neg) begin
            if (w_acc32 > c_MAXP) begin
                w_sat_data = c_MAXP[WIDTH-1:0];
                w_sat_err  = 1'b1;
            end
        end else begin
            if (w_acc32 > c_MAXN) begin
                w_sat_data = WIDTH'(32'd0 - c_MAXN);
                w_sat_err  = 1'b1;
            end else begin
                w_sat_data = WIDTH'(32'd0 - w_acc32);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_count_nxt = r_count;
        w_neg_nxt   = r_neg;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        case (r_state)
            ST_ENTRY: begin
                if (i_key_valid) begin
                    if (i_key_code <= 4'd9) begin
                        if (r_count < c_DIGITS) begin
                            w_buf_nxt   = (r_buf << 4) | c_AW'(i_key_code);
                            w_count_nxt = r_count + 3'd1;
                        end
                    end else if (i_key_code == c_KEY_NEG) begin
                        w_neg_nxt = ~r_neg;
                    end else if (i_key_code == c_KEY_BS) begin
                        if (r_count != 3'd0) begin
                            w_buf_nxt   = r_buf >> 4;
                            w_count_nxt = r_count - 3'd1;
                        end
                    end else if (i_key_code == c_KEY_CLR) begin
                        w_buf_nxt   = '0;
                        w_count_nxt = 3'd0;
                        w_neg_nxt   = 1'b0;
                    end else if (i_key_code == c_KEY_ENT) begin
                        w_acc_nxt   = '0;
                        w_idx_nxt   = c_LAST_IDX;
                        w_state_nxt = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                w_acc_nxt = w_acc_step;
                w_idx_nxt = r_idx - 3'd1;
                // Range check uses the final accumulation combinationally
                if (r_idx == 3'd0) begin
                    w_data_nxt  = w_sat_data;
                    w_err_nxt   = w_sat_err;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_out_ready || w_key_clr) begin
                    w_buf_nxt   = '0;
                    w_count_nxt = 3'd0;
                    w_neg_nxt   = 1'b0;
                    w_state_nxt = ST_ENTRY;
                end
            end
            default: begin
                w_state_nxt = ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_ENTRY;
            r_buf   <= '0;
            r_count <= 3'd0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_idx   <= 3'd0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_count <= w_count_nxt;
            r_neg   <= w_neg_nxt;
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_out_data    = r_data;
    assign o_range_err   = r_err;
    assign o_out_valid   = (r_state == ST_HOLD);
    assign o_busy        = (r_state != ST_ENTRY);
    assign o_disp_bcd    = r_buf;
    assign o_disp_neg    = r_neg;
    assign o_digit_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_keypad_operand_entry.sv
// ============================================================================
// Module   : tb_keypad_operand_entry
// Brief    : Directed self-checking bench, DIGITS=3/WIDTH=8 and DIGITS=5/WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_operand_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        kv1 = 1'b0, rdy1 = 1'b0;
    logic [3:0]  kc1 = 4'h0;
    logic [7:0]  data1;
    logic        val1, err1, busy1, neg1;
    logic [11:0] disp1;
    logic [2:0]  cnt1;

    logic        kv2 = 1'b0, rdy2 = 1'b0;
    logic [3:0]  kc2 = 4'h0;
    logic [15:0] data2;
    logic        val2, err2, busy2, neg2;
    logic [19:0] disp2;
    logic [2:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_operand_entry #(.DIGITS(3), .WIDTH(8)) u_dut1 (
        .clk(clk), .reset(reset), .i_key_valid(kv1), .i_key_code(kc1),
        .o_out_data(data1), .o_out_valid(val1), .i_out_ready(rdy1),
        .o_range_err(err1), .o_busy(busy1), .o_disp_bcd(disp1),
        .o_disp_neg(neg1), .o_digit_count(cnt1)
    );

    keypad_operand_entry #(.DIGITS(5), .WIDTH(16)) u_dut2 (
        .clk(clk), .reset(reset), .i_key_valid(kv2), .i_key_code(kc2),
        .o_out_data(data2), .o_out_valid(val2), .i_out_ready(rdy2),
        .o_range_err(err2), .o_busy(busy2), .o_disp_bcd(disp2),
        .o_disp_neg(neg2), .o_digit_count(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input int sel, input logic [3:0] code);
        @(negedge clk);
        if (sel == 1) begin kv1 = 1'b1; kc1 = code; end
        else          begin kv2 = 1'b1; kc2 = code; end
        @(negedge clk);
        kv1 = 1'b0;
        kv2 = 1'b0;
    endtask

    // Press E, measure cycles to out_valid, then compare the operand
    task automatic convert(input int sel, input string tag, input int lat,
                           input logic [31:0] exp_data, input logic exp_err);
        int n;
        press(sel, 4'hE);
        n = 0;
        while (!((sel == 1) ? val1 : val2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_data"}, (sel == 1) ? 32'(data1) : 32'(data2), exp_data);
        check({tag, "_err"}, (sel == 1) ? 32'(err1) : 32'(err2), 32'(exp_err));
    endtask

    task automatic accept(input int sel, input string tag);
        @(negedge clk);
        if (sel == 1) rdy1 = 1'b1; else rdy2 = 1'b1;
        @(negedge clk);
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        check({tag, "_vld_drop"}, (sel == 1) ? 32'(val1) : 32'(val2), 32'd0);
        check({tag, "_disp_clr"}, (sel == 1) ? 32'(disp1) : 32'(disp2), 32'd0);
        check({tag, "_neg_clr"}, (sel == 1) ? 32'(neg1) : 32'(neg2), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vld"},  32'(val1),  32'd0);
        check({tag, "_data"}, 32'(data1), 32'd0);
        check({tag, "_err"},  32'(err1),  32'd0);
        check({tag, "_busy"}, 32'(busy1), 32'd0);
        check({tag, "_disp"}, 32'(disp1), 32'd0);
        check({tag, "_neg"},  32'(neg1),  32'd0);
        check({tag, "_cnt"},  32'(cnt1),  32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hold_keys [5];
        hold_keys[0] = 4'h1; hold_keys[1] = 4'hA; hold_keys[2] = 4'hE;
        hold_keys[3] = 4'hB; hold_keys[4] = 4'h7;

        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        press(1, 4'h1); press(1, 4'h2); press(1, 4'h7);
        convert(1, "p127", 3, 32'h7F, 1'b0);
        accept(1, "p127");

        press(1, 4'h1); press(1, 4'h2); press(1, 4'h8); press(1, 4'hA);
        convert(1, "n128", 3, 32'h80, 1'b0);
        accept(1, "n128");

        press(1, 4'h1); press(1, 4'h2); press(1, 4'h8);
        convert(1, "p128", 3, 32'h7F, 1'b1);
        accept(1, "p128");

        press(1, 4'h9); press(1, 4'h9); press(1, 4'h9); press(1, 4'hA);
        convert(1, "n999", 3, 32'h80, 1'b1);
        accept(1, "n999");

        press(1, 4'h1); press(1, 4'h2); press(1, 4'h3); press(1, 4'h4);
        check("full_disp", 32'(disp1), 32'h123);
        check("full_cnt",  32'(cnt1),  32'd3);
        press(1, 4'hC);
        check("clr_disp", 32'(disp1), 32'd0);
        check("clr_cnt",  32'(cnt1),  32'd0);

        press(1, 4'h4); press(1, 4'h5); press(1, 4'hB);
        check("bs_disp", 32'(disp1), 32'h4);
        press(1, 4'h6);
        convert(1, "bs46", 3, 32'h2E, 1'b0);
        accept(1, "bs46");

        press(1, 4'hB);
        check("bs0_disp", 32'(disp1), 32'd0);
        check("bs0_cnt",  32'(cnt1),  32'd0);

        press(1, 4'hA);
        check("negonly_flag", 32'(neg1), 32'd1);
        convert(1, "negzero", 3, 32'h00, 1'b0);
        accept(1, "negzero");

        press(1, 4'h5); press(1, 4'h0);
        convert(1, "hold", 3, 32'h32, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_vld",  32'(val1),  32'd1);
            check("hold_data", 32'(data1), 32'h32);
            check("hold_disp", 32'(disp1), 32'h050);
            kv1 = 1'b1;
            kc1 = hold_keys[i % 5];
        end
        @(negedge clk);
        kv1 = 1'b0;
        check("hold_end_vld",  32'(val1),  32'd1);
        check("hold_end_cnt",  32'(cnt1),  32'd2);
        accept(1, "hold");

        press(1, 4'h1); press(1, 4'h2); press(1, 4'hE);
        check("conv_busy", 32'(busy1), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_zero("rst_conv");
        press(1, 4'h3);
        convert(1, "after_rst_conv", 3, 32'h03, 1'b0);
        accept(1, "after_rst_conv");

        press(1, 4'h7);
        convert(1, "pre_rst_hold", 3, 32'h07, 1'b0);
        pulse_reset();
        check_zero("rst_hold");
        press(1, 4'h8); press(1, 4'hA);
        convert(1, "after_rst_hold", 3, 32'hF8, 1'b0);
        accept(1, "after_rst_hold");

        press(1, 4'h9);
        convert(1, "abort", 3, 32'h09, 1'b0);
        press(1, 4'hC);
        check("abort_vld",  32'(val1),  32'd0);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_disp", 32'(disp1), 32'd0);

        press(2, 4'h3); press(2, 4'h2); press(2, 4'h7); press(2, 4'h6); press(2, 4'h7);
        check("w16_disp", 32'(disp2), 32'h32767);
        convert(2, "w16_max", 5, 32'h7FFF, 1'b0);
        accept(2, "w16_max");

        press(2, 4'h9); press(2, 4'h9); press(2, 4'h9); press(2, 4'h9); press(2, 4'h9);
        press(2, 4'hA);
        convert(2, "w16_nsat", 5, 32'h8000, 1'b1);
        accept(2, "w16_nsat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
